// File: rtl/alu_pkg.sv
// Shared ALU opcode and command-driver state types.
// Used by alu, alu_cmd_driver and the bench.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_CMP = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU operand/op interface: holds a command on the ALU inputs,
// waits out the registered zero flag and returns a tagged response.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge where
// valid and ready are both high; once valid is raised its payload is held stable
// and valid stays high until that transfer edge.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic [2:0]       cmd_op_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_carry_i,
    input  logic             alu_error_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_carry_o,
    output logic             rsp_zero_o,
    output logic             rsp_error_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_zmis_o,
    output logic [CNT_W-1:0] op_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output drv_state_e       state_o
);

    drv_state_e state_q, state_d;
    logic       load_cmd, cap_result, cap_zero, rsp_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        load_cmd    = 1'b0;
        cap_result  = 1'b0;
        cap_zero    = 1'b0;
        rsp_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    load_cmd = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                cap_result = 1'b1;
                state_d    = SAMPLE;
            end
            SAMPLE: begin
                cap_zero = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

    // ALU inputs keep the last command after completion; only a new accept changes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_o   <= '0;
            alu_b_o   <= '0;
            alu_op_o  <= '0;
            rsp_tag_o <= '0;
        end else if (load_cmd) begin
            alu_a_o   <= cmd_a_i;
            alu_b_o   <= cmd_b_i;
            alu_op_o  <= cmd_op_i;
            rsp_tag_o <= cmd_tag_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_o <= '0;
            rsp_carry_o  <= 1'b0;
            rsp_error_o  <= 1'b0;
        end else if (cap_result) begin
            rsp_result_o <= alu_result_i;
            rsp_carry_o  <= alu_carry_i;
            rsp_error_o  <= alu_error_i;
        end
    end

    // The zero flag lags the result by one cycle, so it is judged against the captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_zero_o <= 1'b0;
            rsp_zmis_o <= 1'b0;
        end else if (cap_zero) begin
            rsp_zero_o <= alu_zero_i;
            rsp_zmis_o <= alu_zero_i != (rsp_result_o == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_o  <= '0;
            err_count_o <= '0;
        end else if (rsp_done) begin
            if (op_count_o != '1) op_count_o <= op_count_o + 1'b1;
            if ((rsp_error_o || rsp_zmis_o) && (err_count_o != '1))
                err_count_o <= err_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a behavioural ALU drives the alu_* inputs and a
// response model predicts every tagged response and the saturating counters.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready_o;
    logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
    logic [2:0]       cmd_op = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [WIDTH-1:0] alu_a_o, alu_b_o;
    logic [2:0]       alu_op_o;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero_q = 1'b0;
    logic             alu_zero;
    logic             force_zero_low = 1'b0;
    logic             err_inj = 1'b0;
    logic             rsp_valid_o;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result_o;
    logic             rsp_carry_o, rsp_zero_o, rsp_error_o, rsp_zmis_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [CNT_W-1:0] op_count_o, err_count_o;
    drv_state_e       state_o;

    int errors = 0;
    int checks = 0;
    int op_m   = 0;
    int err_m  = 0;
    logic [WIDTH+TAG_W+3:0] exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .cmd_op_i     (cmd_op),
        .cmd_tag_i    (cmd_tag),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_op_o     (alu_op_o),
        .alu_result_i (alu_result),
        .alu_carry_i  (alu_carry),
        .alu_error_i  (err_inj),
        .alu_zero_i   (alu_zero),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result_o),
        .rsp_carry_o  (rsp_carry_o),
        .rsp_zero_o   (rsp_zero_o),
        .rsp_error_o  (rsp_error_o),
        .rsp_tag_o    (rsp_tag_o),
        .rsp_zmis_o   (rsp_zmis_o),
        .op_count_o   (op_count_o),
        .err_count_o  (err_count_o),
        .state_o      (state_o)
    );

    // Reference ALU: {carry, result} from plain arithmetic.
    function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        case (op)
            3'd0: alu_ref = 9'(ai + bi);
            3'd1: alu_ref = {(ai < bi), 8'(ai - bi)};
            3'd2: alu_ref = {1'b0, a & b};
            3'd3: alu_ref = {1'b0, a | b};
            3'd4: alu_ref = {1'b0, a ^ b};
            3'd5: alu_ref = {a[WIDTH-1], 8'(ai * 2)};
            3'd6: alu_ref = {a[0], 8'(ai / 2)};
            default: alu_ref = {1'b0, 8'((ai == bi) ? 1 : 0)};
        endcase
    endfunction

    always_comb {alu_carry, alu_result} = alu_ref(alu_a_o, alu_b_o, alu_op_o);
    always @(posedge clk) alu_zero_q <= (alu_result == '0);
    assign alu_zero = force_zero_low ? 1'b0 : alu_zero_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One full command: accept, latency, response contents, optional stall, handshake, counters.
    task automatic do_cmd(input logic [WIDTH-1:0] a, b, input logic [2:0] op,
                          input logic [TAG_W-1:0] tag, input int stall,
                          input bit fz, input bit fe,
                          output logic [WIDTH-1:0] got_res, output logic got_carry);
        logic [WIDTH:0]         r;
        logic                   zero_e, zmis_e;
        logic [WIDTH+TAG_W+3:0] exp_v, obs_v;
        int cyc;
        cyc = 0;
        while (!cmd_ready_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
        r      = alu_ref(a, b, op);
        zero_e = fz ? 1'b0 : (r[WIDTH-1:0] == '0);
        zmis_e = zero_e != (r[WIDTH-1:0] == '0);
        exp_q.push_back({r[WIDTH-1:0], r[WIDTH], zero_e, fe, zmis_e, tag});
        force_zero_low = fz;
        err_inj   = fe;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
        end while (!rsp_valid_o && cyc < 20);
        check("rsp_latency", 32'(cyc), 32'd3);
        check("alu_a_held", 32'(alu_a_o), 32'(a));
        check("alu_op_held", 32'(alu_op_o), 32'(op));
        exp_v = exp_q.pop_front();
        obs_v = {rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_error_o, rsp_zmis_o, rsp_tag_o};
        check("rsp_fields", 32'(obs_v), 32'(exp_v));
        for (int i = 0; i < stall; i++) begin
            check("stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
            cmd_valid = 1'b1;
            cmd_a = ~a;
            @(negedge clk);
            obs_v = {rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_error_o, rsp_zmis_o, rsp_tag_o};
            check("stall_rsp_stable", 32'({rsp_valid_o, obs_v}), 32'({1'b1, exp_v}));
            check("stall_not_taken", 32'(alu_a_o), 32'(a));
        end
        cmd_valid = 1'b0;
        got_res   = rsp_result_o;
        got_carry = rsp_carry_o;
        rsp_ready = 1'b1;
        check("handshake_cmd_ready", 32'(cmd_ready_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        force_zero_low = 1'b0;
        err_inj = 1'b0;
        op_m = sat_inc(op_m);
        if (fe || zmis_e) err_m = sat_inc(err_m);
        check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("op_count", 32'(op_count_o), 32'(op_m));
        check("err_count", 32'(err_count_o), 32'(err_m));
    endtask

    initial begin
        logic [WIDTH-1:0] res;
        logic             cy;
        bit               seen_valid;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_outputs", 32'({alu_a_o, alu_b_o, alu_op_o, rsp_result_o, rsp_tag_o,
                                  op_count_o, err_count_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_cmd(8'hFF, 8'h01, OP_ADD, 4'd3, 0, 1'b0, 1'b0, res, cy);
        check("add_ff_01", 32'({cy, res, rsp_zero_o, rsp_tag_o}), 32'({1'b1, 8'h00, 1'b1, 4'd3}));
        do_cmd(8'h05, 8'h07, OP_SUB, 4'd5, 0, 1'b0, 1'b0, res, cy);
        check("sub_05_07", 32'({cy, res, rsp_zero_o}), 32'({1'b1, 8'hFE, 1'b0}));
        do_cmd(8'h3C, 8'h3C, OP_CMP, 4'd6, 0, 1'b0, 1'b0, res, cy);
        check("cmp_eq", 32'({res, rsp_zero_o}), 32'({8'h01, 1'b0}));
        do_cmd(8'h10, 8'h20, OP_ADD, 4'd7, 5, 1'b0, 1'b0, res, cy);
        check("add_stalled", 32'(res), 32'h30);
        do_cmd(8'h80, 8'h80, OP_ADD, 4'd8, 0, 1'b1, 1'b0, res, cy);
        check("zmis_forced", 32'({rsp_zmis_o, rsp_zero_o}), 32'({1'b1, 1'b0}));
        do_cmd(8'h12, 8'h34, OP_XOR, 4'd9, 1, 1'b0, 1'b1, res, cy);
        check("err_passthru", 32'(rsp_error_o), 32'd1);

        // Reset in SAMPLE aborts the command
        while (!cmd_ready_o) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a = 8'h44; cmd_b = 8'h11; cmd_op = OP_SUB; cmd_tag = 4'hA;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_state", 32'(state_o), 32'(SAMPLE));
        rst = 1'b1;
        #1;
        op_m = 0;
        err_m = 0;
        check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("mid_rst_counters", 32'({op_count_o, err_count_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid_o) seen_valid = 1'b1;
        end
        check("no_rsp_after_rst", 32'(seen_valid), 32'd0);

        // Back-to-back ops past counter saturation
        for (int i = 0; i < 17; i++)
            do_cmd(8'(i), 8'(3 * i), OP_ADD, 4'(i), 0, 1'b0, 1'b0, res, cy);
        check("op_count_sat", 32'(op_count_o), 32'(CMAX));

        // Randomized commands
        for (int i = 0; i < 20; i++)
            do_cmd(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), 3'($urandom),
                   4'($urandom), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, res, cy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
